// File: rtl/servo_ramp.sv
// servo_ramp -- slew-rate-limited angle sequencer feeding the SG90 servo driver.
//
// Accepts a target angle over a valid/ready handshake, clamps it to MAX_ANGLE,
// then walks angle_raw toward it by STEP degrees per 1 kHz sample tick. Once
// the target is reached it holds for DWELL ticks and pulses done for one clk.
//
// Optional feature macro: SERVO_SWEEP_EN
//   When defined, a sweep input exists. While sweep=1 the block ignores the
//   handshake and ping-pongs between MAX_ANGLE and 0 on its own.
//
// Ports
//   clk        in   system clock
//   nrst       in   asynchronous reset, active low
//   clk_1khz   in   sample tick source, asynchronous to clk
//   tgt_valid  in   target command valid
//   tgt_ready  out  block can accept a command (IDLE only)
//   tgt_angle  in   [7:0] requested angle in degrees
//   angle_raw  out  [7:0] current commanded angle, registered
//   busy       out  high while ramping or settling
//   done       out  one-clk pulse when the dwell period completes
//   sweep      in   autonomous sweep request (SERVO_SWEEP_EN only)

module servo_ramp #(
  parameter int unsigned MAX_ANGLE  = 180,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DWELL      = 500,
  parameter int unsigned INIT_ANGLE = 90
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       clk_1khz,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_angle,
  output logic [7:0] angle_raw,
  output logic       busy,
  output logic       done
`ifdef SERVO_SWEEP_EN
  ,
  input  logic       sweep
`endif
);

  localparam int unsigned CNT_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  localparam logic [7:0]       MAX_C   = 8'(MAX_ANGLE);
  localparam logic [7:0]       INIT_C  = 8'(INIT_ANGLE);
  localparam logic [7:0]       STEP_8  = 8'(STEP);
  localparam logic [8:0]       STEP_9  = 9'(STEP);
  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       angle_q, angle_d;
  logic [7:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two synchroniser flops plus one history flop for edge detection.
  logic [2:0] sync_q;
  logic       tick_p;

  logic [7:0] clamp_in;
  logic       accept;
  logic [8:0] diff;
  logic [8:0] diff_abs;

`ifdef SERVO_SWEEP_EN
  logic sweep_hi_q, sweep_hi_d;
`endif

  // ------------------------------------------------------------------
  // Tick synchroniser and rising-edge detector
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], clk_1khz};
    end
  end

  assign tick_p = sync_q[1] & ~sync_q[2];

  // ------------------------------------------------------------------
  // Handshake and status
  // ------------------------------------------------------------------
`ifdef SERVO_SWEEP_EN
  assign tgt_ready = (state_q == IDLE) && !sweep;
`else
  assign tgt_ready = (state_q == IDLE);
`endif

  assign accept    = tgt_valid & tgt_ready;
  assign clamp_in  = (tgt_angle > MAX_C) ? MAX_C : tgt_angle;
  assign busy      = (state_q != IDLE);
  // Decoded from registered state so that done is high while still in
  // SETTLE; a command offered alongside done therefore sees tgt_ready=0.
  assign done      = (state_q == SETTLE) && (cnt_q == DWELL_C);
  assign angle_raw = angle_q;

  // 9-bit two's-complement distance to target; bit 8 is the sign.
  assign diff     = {1'b0, tgt_q} - {1'b0, angle_q};
  assign diff_abs = diff[8] ? (9'd0 - diff) : diff;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      angle_q <= INIT_C;
      tgt_q   <= INIT_C;
      cnt_q   <= '0;
`ifdef SERVO_SWEEP_EN
      sweep_hi_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
`ifdef SERVO_SWEEP_EN
      sweep_hi_q <= sweep_hi_d;
`endif
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
`ifdef SERVO_SWEEP_EN
    sweep_hi_d = sweep_hi_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Ticks arriving in IDLE (including the acceptance cycle) are ignored.
`ifdef SERVO_SWEEP_EN
        if (sweep) begin
          tgt_d      = sweep_hi_q ? MAX_C : 8'd0;
          sweep_hi_d = ~sweep_hi_q;
          state_d    = RAMP;
        end else
`endif
        if (accept) begin
          tgt_d = clamp_in;
          if (clamp_in == angle_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            state_d = RAMP;
          end
        end
      end

      RAMP: begin
        if (tick_p) begin
          // Snapping to target when within one step prevents overshoot,
          // so angle_raw can never leave [0, MAX_ANGLE] or wrap.
          if (diff_abs <= STEP_9) begin
            angle_d = tgt_q;
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (diff[8]) begin
            angle_d = angle_q - STEP_8;
          end else begin
            angle_d = angle_q + STEP_8;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == DWELL_C) begin
          state_d = IDLE;
        end else if (tick_p) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
